// File: rtl/counter_mode_arbiter.sv
// rtl/counter_mode_arbiter.sv - shared five-button panel and display arbiter for countdown/stopwatch engines
// Optional feature macro: COUNTER_MODE_ARBITER_AUTO_RETURN_EN (idle return from stopwatch view).

module counter_mode_arbiter #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int ALARM_CYCLES    = 300000000,
    parameter int IDLE_CYCLES     = 1000000000
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       center_button,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       mode_button,
    output logic [4:0] cd_btn_o,
    output logic [4:0] sw_btn_o,
    input  logic [7:0] cd_min_i,
    input  logic [7:0] cd_sec_i,
    input  logic [7:0] cd_ms_10_i,
    input  logic [1:0] cd_target_i,
    input  logic       cd_time_out_i,
    input  logic [7:0] sw_min_i,
    input  logic [7:0] sw_sec_i,
    input  logic [7:0] sw_ms_10_i,
    input  logic [1:0] sw_target_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic [7:0] ms_10_o,
    output logic [1:0] target_o,
    output logic       mode_o,
    output logic       alarm_o
);
    localparam int NBTN = 6;
    localparam int MODE = 5;
    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW   = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);

    typedef enum logic [1:0] {
        CD_VIEW = 2'd0,
        SW_VIEW = 2'd1,
        ALARM   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NBTN-1:0] raw_btn;
    logic [NBTN-1:0] sync_0;
    logic [NBTN-1:0] sync_1;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] stable_d;
    logic [NBTN-1:0] press;
    logic [CW-1:0]   db_cnt [NBTN];
    logic [AW-1:0]   alarm_cnt;
    logic [AW-1:0]   alarm_cnt_next;
    logic            to_d;
    logic            to_rise;
    logic            any_press;

    // Bit 5 is the mode button; bits 4..0 line up with the engine pulse buses.
    assign raw_btn   = {mode_button, left_button, right_button, center_button, up_button, down_button};
    assign to_rise   = cd_time_out_i & ~to_d;
    assign any_press = |press;

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            sync_0   <= '0;
            sync_1   <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_0   <= raw_btn;
            sync_1   <= sync_0;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable[i] <= sync_1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef COUNTER_MODE_ARBITER_AUTO_RETURN_EN
    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);

    logic [IW-1:0] idle_cnt;
    logic          idle_hit;

    assign idle_hit = (state == SW_VIEW) && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if ((state != SW_VIEW) || any_press || idle_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end
`else
    logic unused_idle_cfg;
    assign unused_idle_cfg = (IDLE_CYCLES != 0);
`endif

    // A new time-out edge outranks every other event, including a press in the same cycle.
    always_comb begin
        state_next     = state;
        alarm_cnt_next = alarm_cnt;
        case (state)
            CD_VIEW: begin
                if (to_rise) begin
                    state_next     = ALARM;
                    alarm_cnt_next = ALARM_LOAD;
                end else if (press[MODE]) begin
                    state_next = SW_VIEW;
                end
            end
            SW_VIEW: begin
                if (to_rise) begin
                    state_next     = ALARM;
                    alarm_cnt_next = ALARM_LOAD;
                end else if (press[MODE]) begin
                    state_next = CD_VIEW;
                end
`ifdef COUNTER_MODE_ARBITER_AUTO_RETURN_EN
                else if (idle_hit && !any_press) begin
                    state_next = CD_VIEW;
                end
`endif
            end
            ALARM: begin
                if (to_rise) begin
                    alarm_cnt_next = ALARM_LOAD;
                end else if (any_press || (alarm_cnt == '0)) begin
                    state_next = CD_VIEW;
                end else begin
                    alarm_cnt_next = alarm_cnt - AW'(1);
                end
            end
            default: begin
                state_next = CD_VIEW;
            end
        endcase
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state     <= CD_VIEW;
            alarm_cnt <= '0;
            to_d      <= 1'b0;
            mode_o    <= 1'b0;
            alarm_o   <= 1'b0;
            cd_btn_o  <= '0;
            sw_btn_o  <= '0;
            min_o     <= '0;
            sec_o     <= '0;
            ms_10_o   <= '0;
            target_o  <= '0;
        end else begin
            state     <= state_next;
            alarm_cnt <= alarm_cnt_next;
            to_d      <= cd_time_out_i;
            mode_o    <= (state_next == SW_VIEW);
            alarm_o   <= (state_next == ALARM);
            cd_btn_o  <= (state == CD_VIEW) ? press[4:0] : 5'b0;
            sw_btn_o  <= (state == SW_VIEW) ? press[4:0] : 5'b0;
            if (mode_o) begin
                min_o    <= sw_min_i;
                sec_o    <= sw_sec_i;
                ms_10_o  <= sw_ms_10_i;
                target_o <= sw_target_i;
            end else begin
                min_o    <= cd_min_i;
                sec_o    <= cd_sec_i;
                ms_10_o  <= cd_ms_10_i;
                target_o <= cd_target_i;
            end
        end
    end
endmodule

// File: tb/tb_counter_mode_arbiter.sv
// tb/tb_counter_mode_arbiter.sv - self-checking bench for counter_mode_arbiter
// Window-based debounce model and deadline-based alarm model, checked every cycle.

module tb_counter_mode_arbiter;
    localparam int D = 4;
    localparam int A = 20;
    localparam int I = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = 6'b0;
    logic [7:0] cd_min_i = 8'h05;
    logic [7:0] cd_sec_i = 8'h30;
    logic [7:0] cd_ms_10_i = 8'h99;
    logic [1:0] cd_target_i = 2'd1;
    logic       cd_time_out_i = 1'b0;
    logic [7:0] sw_min_i = 8'h12;
    logic [7:0] sw_sec_i = 8'h47;
    logic [7:0] sw_ms_10_i = 8'h01;
    logic [1:0] sw_target_i = 2'd2;
    logic [4:0] cd_btn_o;
    logic [4:0] sw_btn_o;
    logic [7:0] min_o;
    logic [7:0] sec_o;
    logic [7:0] ms_10_o;
    logic [1:0] target_o;
    logic       mode_o;
    logic       alarm_o;

    always #5 clk = ~clk;

    counter_mode_arbiter #(
        .DEBOUNCE_CYCLES(D),
        .ALARM_CYCLES(A),
        .IDLE_CYCLES(I)
    ) dut (
        .clk_core(clk),
        .rst(rst),
        .left_button(btn[4]),
        .right_button(btn[3]),
        .center_button(btn[2]),
        .up_button(btn[1]),
        .down_button(btn[0]),
        .mode_button(btn[5]),
        .cd_btn_o(cd_btn_o),
        .sw_btn_o(sw_btn_o),
        .cd_min_i(cd_min_i),
        .cd_sec_i(cd_sec_i),
        .cd_ms_10_i(cd_ms_10_i),
        .cd_target_i(cd_target_i),
        .cd_time_out_i(cd_time_out_i),
        .sw_min_i(sw_min_i),
        .sw_sec_i(sw_sec_i),
        .sw_ms_10_i(sw_ms_10_i),
        .sw_target_i(sw_target_i),
        .min_o(min_o),
        .sec_o(sec_o),
        .ms_10_o(ms_10_o),
        .target_o(target_o),
        .mode_o(mode_o),
        .alarm_o(alarm_o)
    );

    // Behavioural model: stable level flips once D consecutive synchronized samples disagree with it.
    logic [5:0] hist [0:D+1];
    logic [5:0] m_stable, m_rose, m_press, rose_now;
    logic       m_sw, m_alarm, m_to_prev, all_flip;
    int         cyc = 0;
    int         alarm_end = 0;
`ifdef COUNTER_MODE_ARBITER_AUTO_RETURN_EN
    int         last_act = 0;
`endif
    logic [4:0] e_cd = '0, e_sw = '0;
    logic [7:0] e_min = '0, e_sec = '0, e_ms = '0;
    logic [1:0] e_tgt = '0;
    logic       e_mode = 1'b0, e_alarm = 1'b0;

    always @(posedge clk or posedge rst) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int k = 0; k < D + 2; k++) hist[k] = '0;
            m_stable = '0; m_rose = '0; m_press = '0;
            m_sw = 1'b0; m_alarm = 1'b0; m_to_prev = 1'b0;
            e_cd = '0; e_sw = '0; e_min = '0; e_sec = '0; e_ms = '0; e_tgt = '0;
            e_mode = 1'b0; e_alarm = 1'b0;
        end else begin
            e_cd = (!m_alarm && !m_sw) ? m_press[4:0] : 5'b0;
            e_sw = (!m_alarm && m_sw) ? m_press[4:0] : 5'b0;
            if (e_mode) begin
                e_min = sw_min_i; e_sec = sw_sec_i; e_ms = sw_ms_10_i; e_tgt = sw_target_i;
            end else begin
                e_min = cd_min_i; e_sec = cd_sec_i; e_ms = cd_ms_10_i; e_tgt = cd_target_i;
            end
            if (cd_time_out_i && !m_to_prev) begin
                m_alarm = 1'b1;
                m_sw = 1'b0;
                alarm_end = cyc + A;
            end else if (m_alarm) begin
                if (m_press != 6'b0 || cyc == alarm_end) m_alarm = 1'b0;
            end else if (m_press[5]) begin
                m_sw = !m_sw;
            end
`ifdef COUNTER_MODE_ARBITER_AUTO_RETURN_EN
            else if (m_sw && m_press == 6'b0 && (cyc - last_act) == I) begin
                m_sw = 1'b0;
            end
            if (m_press != 6'b0) last_act = cyc;
`endif
            e_mode = m_sw && !m_alarm;
            e_alarm = m_alarm;
            m_to_prev = cd_time_out_i;
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn;
            rose_now = '0;
            for (int b = 0; b < 6; b++) begin
                all_flip = 1'b1;
                for (int k = 2; k < D + 2; k++) begin
                    if (hist[k][b] == m_stable[b]) all_flip = 1'b0;
                end
                if (all_flip) begin
                    m_stable[b] = ~m_stable[b];
                    rose_now[b] = m_stable[b];
                end
            end
            m_press = m_rose;
            m_rose = rose_now;
        end
    end

    // Pulse/level monitor: running totals the stimulus compares before and after each scenario.
    int         tot_cd = 0, tot_sw = 0, tot_alarm = 0;
    logic [4:0] last_cd = '0, last_sw = '0;

    always @(negedge clk) begin
        if (cd_btn_o != 5'b0) begin tot_cd++; last_cd = cd_btn_o; end
        if (sw_btn_o != 5'b0) begin tot_sw++; last_sw = sw_btn_o; end
        if (alarm_o) tot_alarm++;
    end

    // Literal expectations posted by the stimulus, drained by the compare process.
    string       lit_name [0:127];
    logic [31:0] lit_act  [0:127];
    logic [31:0] lit_exp  [0:127];
    int          lit_wr = 0;
    int          lit_rd = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name[lit_wr] = name;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cd_btn_o", 32'(cd_btn_o), 32'(e_cd));
        check("sw_btn_o", 32'(sw_btn_o), 32'(e_sw));
        check("min_o", 32'(min_o), 32'(e_min));
        check("sec_o", 32'(sec_o), 32'(e_sec));
        check("ms_10_o", 32'(ms_10_o), 32'(e_ms));
        check("target_o", 32'(target_o), 32'(e_tgt));
        check("mode_o", 32'(mode_o), 32'(e_mode));
        check("alarm_o", 32'(alarm_o), 32'(e_alarm));
        while (lit_rd < lit_wr) begin
            check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [5:0] mask, input int hold, input int rel);
        btn = mask;
        tick(hold);
        btn = 6'b0;
        tick(rel);
    endtask

    int base_cd, base_sw, base_al;

    initial begin
        tick(3);
        expect_lit("reset_outputs", {cd_btn_o, sw_btn_o, min_o, sec_o, ms_10_o[5:0]}, 32'h0);
        expect_lit("reset_mode_alarm", {target_o, mode_o, alarm_o}, 32'h0);
        rst = 1'b0;
        tick(4);

        // Bounce rejection on center, then a clean hold and release.
        base_cd = tot_cd; base_sw = tot_sw;
        for (int i = 0; i < 3; i++) begin
            btn = 6'b000100; tick(2);
            btn = 6'b000000; tick(2);
        end
        push(6'b000100, 12, 12);
        expect_lit("bounce_pulse_count", tot_cd - base_cd, 1);
        expect_lit("bounce_pulse_value", 32'(last_cd), 32'h04);
        expect_lit("bounce_sw_quiet", tot_sw - base_sw, 0);

        // Simultaneous left+down in countdown view.
        base_cd = tot_cd;
        push(6'b010001, 8, 8);
        expect_lit("multi_pulse_count", tot_cd - base_cd, 1);
        expect_lit("multi_pulse_value", 32'(last_cd), 32'h11);

        // Mode switch to stopwatch, then up goes to the stopwatch only.
        base_cd = tot_cd; base_sw = tot_sw;
        push(6'b100000, 8, 8);
        expect_lit("mode_sw_view", 32'(mode_o), 1);
        expect_lit("mode_min_sw", 32'(min_o), 32'h12);
        expect_lit("mode_no_fwd", (tot_cd - base_cd) + (tot_sw - base_sw), 0);
        base_cd = tot_cd; base_sw = tot_sw;
        push(6'b000010, 8, 8);
        expect_lit("up_sw_count", tot_sw - base_sw, 1);
        expect_lit("up_sw_value", 32'(last_sw), 32'h02);
        expect_lit("up_cd_quiet", tot_cd - base_cd, 0);

        // Alarm entry from stopwatch view and auto-expiry with time-out still high.
        base_al = tot_alarm;
        cd_time_out_i = 1'b1;
        tick(1);
        expect_lit("alarm_entry", {mode_o, alarm_o}, 32'h1);
        tick(1);
        expect_lit("alarm_min_cd", 32'(min_o), 32'h05);
        tick(30);
        expect_lit("alarm_len", tot_alarm - base_al, A);
        expect_lit("alarm_expired", {mode_o, alarm_o}, 32'h0);
        cd_time_out_i = 1'b0;
        tick(2);

        // Acknowledge alarm with left: consumed; next left reaches countdown.
        cd_time_out_i = 1'b1;
        tick(2);
        expect_lit("ack_alarm_on", 32'(alarm_o), 1);
        base_cd = tot_cd; base_sw = tot_sw;
        push(6'b010000, 8, 8);
        expect_lit("ack_alarm_off", 32'(alarm_o), 0);
        expect_lit("ack_consumed", (tot_cd - base_cd) + (tot_sw - base_sw), 0);
        cd_time_out_i = 1'b0;
        tick(2);
        base_cd = tot_cd;
        push(6'b010000, 8, 8);
        expect_lit("left_after_ack", 32'(last_cd), 32'h10);
        expect_lit("left_after_ack_count", tot_cd - base_cd, 1);

        // Asynchronous reset in the middle of an alarm.
        cd_time_out_i = 1'b1;
        tick(3);
        expect_lit("pre_reset_alarm", 32'(alarm_o), 1);
        #1 rst = 1'b1;
        #1 expect_lit("async_reset_alarm", 32'(alarm_o), 0);
        cd_time_out_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);

        // Time-out edge coincident with the mode press pulse.
        btn = 6'b100000;
        tick(7);
        cd_time_out_i = 1'b1;
        tick(1);
        expect_lit("coincide_alarm", {mode_o, alarm_o}, 32'h1);
        btn = 6'b0;
        tick(25);
        expect_lit("coincide_after", {mode_o, alarm_o}, 32'h0);
        cd_time_out_i = 1'b0;
        tick(2);

        // Idle in stopwatch view.
        push(6'b100000, 8, 8);
        expect_lit("idle_enter_sw", 32'(mode_o), 1);
        tick(60);
`ifdef COUNTER_MODE_ARBITER_AUTO_RETURN_EN
        expect_lit("idle_auto_return", 32'(mode_o), 0);
`else
        expect_lit("idle_stays_sw", 32'(mode_o), 1);
`endif
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_mode_arbiter.md
Name:
counter_mode_arbiter

Overview:
- Front-panel controller that shares one raw five-button panel and one display path between two timer engines: the countdown commander (mode 0) and the stopwatch commander (mode 1).
- Debounces the raw buttons, turns each press into a one-cycle pulse, and routes the pulse to the active engine only.
- Registers the active engine's time fields onto the display outputs.
- Forces an alarm view when the countdown expires.

Parameters:
- DEBOUNCE_CYCLES, 2000000: consecutive identical samples required to accept a new button level (20 ms at 100 MHz).
- ALARM_CYCLES, 300000000: alarm auto-expiry time in clk_core cycles.
- IDLE_CYCLES, 1000000000: idle timeout before returning to countdown view. Used only with AUTO_RETURN_EN.

Ports:
- clk_core  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- left_button, right_button, center_button, up_button, down_button  in  1 each  raw, asynchronous, bouncing button inputs.
- mode_button  in  1  raw mode-select button.
- cd_btn_o  out  5  pulses to the countdown engine, bit order {left,right,center,up,down} = [4:0].
- sw_btn_o  out  5  pulses to the stopwatch engine, same bit order.
- cd_min_i, cd_sec_i, cd_ms_10_i  in  8 each  countdown BCD fields.
- cd_target_i  in  2  countdown edit-field select.
- cd_time_out_i  in  1  countdown expired (level).
- sw_min_i, sw_sec_i, sw_ms_10_i  in  8 each  stopwatch BCD fields.
- sw_target_i  in  2  stopwatch edit-field select.
- min_o, sec_o, ms_10_o  out  8 each  displayed BCD fields.
- target_o  out  2  displayed edit-field select.
- mode_o  out  1  0 = countdown shown, 1 = stopwatch shown.
- alarm_o  out  1  alarm active.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in CD_VIEW, debounced levels 0, all counters 0, time_out edge detector cleared.
- Per-button conditioning (six identical channels):
  - 2-flop synchronizer.
  - Counter runs while the synchronized sample differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level is updated and the counter clears.
  - A rising edge of the stable level produces a 1-cycle press pulse. Falling edges produce nothing.
  - Latency from a clean input edge to the pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Pulse routing (registered, 1 cycle after the press pulse):
  - CD_VIEW: the pulse goes to cd_btn_o; sw_btn_o stays 0.
  - SW_VIEW: the pulse goes to sw_btn_o; cd_btn_o stays 0.
  - ALARM: nothing is forwarded.
  - Mode presses are never forwarded to either engine.
  - Several simultaneous presses are forwarded together on their own bits.
- FSM, states CD_VIEW / SW_VIEW / ALARM:
  - CD_VIEW: mode press -> SW_VIEW.
  - SW_VIEW: mode press -> CD_VIEW.
  - CD_VIEW or SW_VIEW: rising edge of cd_time_out_i -> ALARM, alarm timer loaded with ALARM_CYCLES-1.
  - ALARM: any press (including mode) -> CD_VIEW. The press is consumed.
  - ALARM: alarm timer reaches 0 -> CD_VIEW.
  - Edge and mode press in the same cycle: ALARM wins and the mode press is dropped.
  - cd_time_out_i held high does not re-trigger. A new rising edge is required.
  - A rising edge while already in ALARM reloads the timer.
- Outputs:
  - mode_o = 1 only in SW_VIEW.
  - alarm_o = 1 only in ALARM.
  - Both are registered, so they change 1 cycle after the transition condition.
- Display mux (registered, 1-cycle latency):
  - mode_o=1: min/sec/ms_10/target show the sw_* inputs.
  - mode_o=0 (including ALARM): they show the cd_* inputs.
  - Fields are passed through unchanged; no BCD checking.

Optional Feature:
- Macro: COUNTER_MODE_ARBITER_AUTO_RETURN_EN.
- Defined:
  - An idle counter runs in SW_VIEW and clears on any press.
  - When it reaches IDLE_CYCLES-1, the FSM returns to CD_VIEW.
  - ALARM entry has priority over auto-return in the same cycle.
- Undefined: no idle counter; SW_VIEW is left only by a mode press or ALARM entry.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ALARM_CYCLES=20, IDLE_CYCLES=50.
- Reset: assert rst with all inputs at 0 -> every output 0, mode_o=0, alarm_o=0.
- Bounce rejection: center_button toggles every 2 cycles for 12 cycles, then held 1 -> exactly one cd_btn_o=5'b00100 pulse, 1 cycle wide; sw_btn_o stays 0; release produces nothing.
- Mode switch: drive sw_min_i=8'h12 and cd_min_i=8'h05, then press mode -> mode_o=1; min_o=8'h12 one cycle later. Then press up -> sw_btn_o=5'b00010 pulse only.
- Alarm entry and expiry: in SW_VIEW raise cd_time_out_i -> mode_o=0, alarm_o=1, display shows cd_*. alarm_o drops after 20 cycles; state is CD_VIEW while cd_time_out_i is still high.
- Alarm acknowledge: during ALARM press left -> alarm_o=0, no pulse on either engine's output. The next left press -> cd_btn_o=5'b10000.
- Reset mid-operation and simultaneous events:
  - Assert rst asynchronously mid-ALARM -> alarm_o=0 immediately.
  - cd_time_out_i rising edge coincident with a mode pulse -> ALARM entered, mode_o stays 0.
  - With AUTO_RETURN_EN defined: 50 idle cycles in SW_VIEW -> mode_o=0.
